// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus bundle.
//   slave  : view taken by id_ex_stage (decoded ID fields, bypass sources and
//            flush/hold come in; ALU operands, controls and stall go out).
//   master : view taken by the surrounding pipeline (or a bench).
// Parameters must match those of the id_ex_stage instance using it.
interface id_ex_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  // ID stage
  logic                  id_valid_87;
  logic [REG_ADDR_W-1:0] id_rs_87;
  logic [REG_ADDR_W-1:0] id_rt_87;
  logic [REG_ADDR_W-1:0] id_rd_87;
  logic [DATA_WIDTH-1:0] id_rs_data_87;
  logic [DATA_WIDTH-1:0] id_rt_data_87;
  logic [DATA_WIDTH-1:0] id_imm_87;
  logic                  id_use_imm_87;
  logic [3:0]            id_alu_op_87;
  logic                  id_reg_write_87;
  logic                  id_mem_read_87;
  logic                  id_mem_write_87;
  // bypass sources
  logic                  mem_reg_write_87;
  logic [REG_ADDR_W-1:0] mem_rd_87;
  logic [DATA_WIDTH-1:0] mem_result_87;
  logic                  wb_reg_write_87;
  logic [REG_ADDR_W-1:0] wb_rd_87;
  logic [DATA_WIDTH-1:0] wb_result_87;
  // pipeline control
  logic                  flush_87;
  logic                  hold_87;
  logic                  stall_87;
  // EX stage
  logic [DATA_WIDTH-1:0] ex_arg_a_87;
  logic [DATA_WIDTH-1:0] ex_arg_b_87;
  logic [3:0]            ex_alu_op_87;
  logic                  ex_alu_en_87;
  logic [DATA_WIDTH-1:0] ex_store_data_87;
  logic [REG_ADDR_W-1:0] ex_rd_87;
  logic                  ex_reg_write_87;
  logic                  ex_mem_read_87;
  logic                  ex_mem_write_87;
  logic [CNT_W-1:0]      stall_cnt_87;

  modport slave (
    input  id_valid_87, id_rs_87, id_rt_87, id_rd_87, id_rs_data_87, id_rt_data_87,
           id_imm_87, id_use_imm_87, id_alu_op_87, id_reg_write_87, id_mem_read_87,
           id_mem_write_87, mem_reg_write_87, mem_rd_87, mem_result_87,
           wb_reg_write_87, wb_rd_87, wb_result_87, flush_87, hold_87,
    output stall_87, ex_arg_a_87, ex_arg_b_87, ex_alu_op_87, ex_alu_en_87,
           ex_store_data_87, ex_rd_87, ex_reg_write_87, ex_mem_read_87,
           ex_mem_write_87, stall_cnt_87
  );

  modport master (
    output id_valid_87, id_rs_87, id_rt_87, id_rd_87, id_rs_data_87, id_rt_data_87,
           id_imm_87, id_use_imm_87, id_alu_op_87, id_reg_write_87, id_mem_read_87,
           id_mem_write_87, mem_reg_write_87, mem_rd_87, mem_result_87,
           wb_reg_write_87, wb_rd_87, wb_result_87, flush_87, hold_87,
    input  stall_87, ex_arg_a_87, ex_arg_b_87, ex_alu_op_87, ex_alu_en_87,
           ex_store_data_87, ex_rd_87, ex_reg_write_87, ex_mem_read_87,
           ex_mem_write_87, stall_cnt_87
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU.
//   clk_87 / rst_87 : clock, synchronous active-high reset.
//   bus (slave)     : ID fields in, EX/MEM + MEM/WB bypass in, flush/hold in;
//                     forwarded ALU operands, registered controls, load-use
//                     stall and saturating stall counter out.
// Register update priority: reset > flush > hold > load-use stall > load.
module id_ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic          clk_87,
  input  logic          rst_87,
  id_ex_stage_if.slave  bus
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_WIDTH-1:0] rs_data;
    logic [DATA_WIDTH-1:0] rt_data;
    logic [DATA_WIDTH-1:0] imm;
    logic                  use_imm;
    logic [3:0]            alu_op;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
  } ex_t;

  ex_t              ex_q, ex_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             stall;

  // EX/MEM wins over MEM/WB; r0 is never bypassed.
  function automatic logic [DATA_WIDTH-1:0] fwd(
    input logic [REG_ADDR_W-1:0] src,
    input logic [DATA_WIDTH-1:0] captured
  );
    if (bus.mem_reg_write_87 && bus.mem_rd_87 != '0 && bus.mem_rd_87 == src)
      return bus.mem_result_87;
    else if (bus.wb_reg_write_87 && bus.wb_rd_87 != '0 && bus.wb_rd_87 == src)
      return bus.wb_result_87;
    else
      return captured;
  endfunction

  always_comb begin
    // rt only matters when it is actually read: as ALU operand or store data.
    stall = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && bus.id_valid_87 &&
            ((bus.id_rs_87 == ex_q.rd) ||
             ((bus.id_rt_87 == ex_q.rd) && (!bus.id_use_imm_87 || bus.id_mem_write_87))) &&
            !bus.flush_87 && !bus.hold_87;

    ex_d = ex_q;
    if (bus.flush_87 || (!bus.hold_87 && stall)) begin
      // bubble: datapath fields left as-is, only valid/controls cleared
      ex_d.valid     = 1'b0;
      ex_d.reg_write = 1'b0;
      ex_d.mem_read  = 1'b0;
      ex_d.mem_write = 1'b0;
    end else if (!bus.hold_87) begin
      ex_d.valid     = bus.id_valid_87;
      ex_d.rs        = bus.id_rs_87;
      ex_d.rt        = bus.id_rt_87;
      ex_d.rd        = bus.id_rd_87;
      ex_d.rs_data   = bus.id_rs_data_87;
      ex_d.rt_data   = bus.id_rt_data_87;
      ex_d.imm       = bus.id_imm_87;
      ex_d.use_imm   = bus.id_use_imm_87;
      ex_d.alu_op    = bus.id_alu_op_87;
      ex_d.reg_write = bus.id_reg_write_87 & bus.id_valid_87;
      ex_d.mem_read  = bus.id_mem_read_87  & bus.id_valid_87;
      ex_d.mem_write = bus.id_mem_write_87 & bus.id_valid_87;
    end

    // Counts bubbles that displace a real instruction. A flush that coincides
    // with hold still kills the ID instruction, so it counts too; stall is
    // already forced low under hold.
    stall_cnt_d = stall_cnt_q;
    if (((bus.flush_87 && bus.id_valid_87) || stall) && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_87) begin
    if (rst_87) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  logic [DATA_WIDTH-1:0] rt_fwd;
  assign rt_fwd = fwd(ex_q.rt, ex_q.rt_data);

  assign bus.stall_87         = stall;
  assign bus.ex_arg_a_87      = fwd(ex_q.rs, ex_q.rs_data);
  assign bus.ex_arg_b_87      = ex_q.use_imm ? ex_q.imm : rt_fwd;
  assign bus.ex_store_data_87 = rt_fwd;
  assign bus.ex_alu_op_87     = ex_q.alu_op;
  assign bus.ex_alu_en_87     = ex_q.valid;
  assign bus.ex_rd_87         = ex_q.rd;
  assign bus.ex_reg_write_87  = ex_q.reg_write & ex_q.valid;
  assign bus.ex_mem_read_87   = ex_q.mem_read  & ex_q.valid;
  assign bus.ex_mem_write_87  = ex_q.mem_write & ex_q.valid;
  assign bus.stall_cnt_87     = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 16;
  localparam logic [3:0] OP_ADD = 4'h2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc_n = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  id_ex_stage_if #(.DATA_WIDTH(DW), .REG_ADDR_W(RW), .CNT_W(CW)) bus ();

  id_ex_stage #(.DATA_WIDTH(DW), .REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk_87(clk),
    .rst_87(rst),
    .bus   (bus)
  );

  typedef struct {
    int             cyc;
    string          name;
    bit             chk_args;
    bit             chk_cnt;
    logic           en;
    logic [DW-1:0]  a, b, sd;
    logic [3:0]     op;
    logic [RW-1:0]  rd;
    logic           rw, mr, mw, st;
    logic [CW-1:0]  cnt;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  task automatic push(input string name, input bit chk_args, input logic en,
                      input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [DW-1:0] sd, input logic [3:0] op,
                      input logic [RW-1:0] rd, input logic rw, input logic mr,
                      input logic mw, input logic st, input bit chk_cnt,
                      input logic [CW-1:0] cnt);
    exp_t x;
    x.cyc = cyc_n; x.name = name; x.chk_args = chk_args; x.chk_cnt = chk_cnt;
    x.en = en; x.a = a; x.b = b; x.sd = sd; x.op = op; x.rd = rd;
    x.rw = rw; x.mr = mr; x.mw = mw; x.st = st; x.cnt = cnt;
    sb.push_back(x);
  endtask

  // Monitor: compares every expectation scheduled for the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc_n) begin
      bit ok;
      e = sb.pop_front();
      checks++;
      if (e.cyc < cyc_n) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", e.name, e.cyc, cyc_n);
      end else begin
        ok = (bus.ex_alu_en_87 === e.en) && (bus.ex_reg_write_87 === e.rw) &&
             (bus.ex_mem_read_87 === e.mr) && (bus.ex_mem_write_87 === e.mw) &&
             (bus.stall_87 === e.st);
        if (e.chk_args)
          ok = ok && (bus.ex_arg_a_87 === e.a) && (bus.ex_arg_b_87 === e.b) &&
               (bus.ex_store_data_87 === e.sd) && (bus.ex_alu_op_87 === e.op) &&
               (bus.ex_rd_87 === e.rd);
        if (e.chk_cnt) ok = ok && (bus.stall_cnt_87 === e.cnt);
        if (!ok) begin
          errors++;
          $display("FAIL %s: got en=%0b a=%h b=%h sd=%h op=%h rd=%0d rw=%0b mr=%0b mw=%0b st=%0b cnt=%h; want en=%0b a=%h b=%h sd=%h op=%h rd=%0d rw=%0b mr=%0b mw=%0b st=%0b cnt=%h (args %0b cnt %0b)",
                   e.name, bus.ex_alu_en_87, bus.ex_arg_a_87, bus.ex_arg_b_87,
                   bus.ex_store_data_87, bus.ex_alu_op_87, bus.ex_rd_87,
                   bus.ex_reg_write_87, bus.ex_mem_read_87, bus.ex_mem_write_87,
                   bus.stall_87, bus.stall_cnt_87, e.en, e.a, e.b, e.sd, e.op,
                   e.rd, e.rw, e.mr, e.mw, e.st, e.cnt, e.chk_args, e.chk_cnt);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                        input logic [RW-1:0] rd, input logic [DW-1:0] rsd,
                        input logic [DW-1:0] rtd, input logic [DW-1:0] imm,
                        input logic ui, input logic rw, input logic mr, input logic mw);
    bus.id_valid_87 = v;  bus.id_rs_87 = rs;  bus.id_rt_87 = rt;  bus.id_rd_87 = rd;
    bus.id_rs_data_87 = rsd;  bus.id_rt_data_87 = rtd;  bus.id_imm_87 = imm;
    bus.id_use_imm_87 = ui;  bus.id_alu_op_87 = OP_ADD;
    bus.id_reg_write_87 = rw;  bus.id_mem_read_87 = mr;  bus.id_mem_write_87 = mw;
  endtask

  task automatic clr_id();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.id_alu_op_87 = 4'h0;
  endtask

  task automatic set_fwd(input logic mw, input logic [RW-1:0] mrd, input logic [DW-1:0] mres,
                         input logic ww, input logic [RW-1:0] wrd, input logic [DW-1:0] wres);
    bus.mem_reg_write_87 = mw; bus.mem_rd_87 = mrd; bus.mem_result_87 = mres;
    bus.wb_reg_write_87 = ww;  bus.wb_rd_87 = wrd;  bus.wb_result_87 = wres;
  endtask

  // LW r4, 8(r1) with r1=0x100
  task automatic id_lw();
    set_id(1, 5'd1, 5'd4, 5'd4, 32'h100, 32'h0, 32'h8, 1, 1, 1, 0);
  endtask

  // ADD r6, r4, r2 with stale r4=0, r2=7
  task automatic id_add_dep();
    set_id(1, 5'd4, 5'd2, 5'd6, 32'h0, 32'h7, 32'h0, 0, 1, 0, 0);
  endtask

  initial begin
    clr_id();
    set_fwd(0, 0, 0, 0, 0, 0);
    bus.flush_87 = 0; bus.hold_87 = 0;
    rst = 1;
    cyc(); cyc();
    push("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    // ADD r3, r1, r2
    cyc(); rst = 0;
    set_id(1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, 0, 1, 0, 0);
    push("idle_after_reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc();
    push("add_basic", 1, 1, 32'd5, 32'd7, 32'd7, OP_ADD, 5'd3, 1, 0, 0, 0, 1, 0);
    // ADDI r5, r3, 4  (rt=r0 carries 0x55 as captured store data)
    set_id(1, 5'd3, 5'd0, 5'd5, 32'h99, 32'h55, 32'h4, 1, 1, 0, 0);

    cyc(); clr_id(); bus.hold_87 = 1;
    set_fwd(1, 5'd3, 32'h10, 1, 5'd3, 32'h20);
    push("fwd_mem_prio", 1, 1, 32'h10, 32'h4, 32'h55, OP_ADD, 5'd5, 1, 0, 0, 0, 1, 0);
    cyc(); bus.mem_reg_write_87 = 0;
    push("fwd_wb", 1, 1, 32'h20, 32'h4, 32'h55, OP_ADD, 5'd5, 1, 0, 0, 0, 1, 0);
    cyc(); set_fwd(1, 5'd0, 32'h10, 1, 5'd0, 32'h20);
    push("fwd_rd0", 1, 1, 32'h99, 32'h4, 32'h55, OP_ADD, 5'd5, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      push("hold_const", 1, 1, 32'h99, 32'h4, 32'h55, OP_ADD, 5'd5, 1, 0, 0, 0, 1, 0);
    end

    cyc(); bus.hold_87 = 0; set_fwd(0, 0, 0, 0, 0, 0);
    id_lw();
    push("pre_lw", 1, 1, 32'h99, 32'h4, 32'h55, OP_ADD, 5'd5, 1, 0, 0, 0, 1, 0);
    cyc(); id_add_dep();
    push("lu_stall_rs", 1, 1, 32'h100, 32'h8, 32'h0, OP_ADD, 5'd4, 1, 1, 0, 1, 1, 0);
    cyc();
    push("lu_bubble", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'd1);
    cyc(); set_fwd(1, 5'd2, 32'h33, 1, 5'd4, 32'hABC);
    push("lu_fwd_wb_mem", 1, 1, 32'hABC, 32'h33, 32'h33, OP_ADD, 5'd6, 1, 0, 0, 0, 1, 16'd1);
    id_lw();

    // ADDI r7, r1, 0x10 with rt=r4 unused: no stall
    cyc(); set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 5'd1, 5'd4, 5'd7, 32'h1, 32'h0, 32'h10, 1, 1, 0, 0);
    push("lu_imm_nostall", 1, 1, 32'h100, 32'h8, 32'h0, OP_ADD, 5'd4, 1, 1, 0, 0, 1, 16'd1);
    cyc(); id_lw();
    push("addi", 1, 1, 32'h1, 32'h10, 32'h0, OP_ADD, 5'd7, 1, 0, 0, 0, 1, 16'd1);
    // SW r4, 0xC(r1): rt is store data, so it stalls despite use_imm
    cyc(); set_id(1, 5'd1, 5'd4, 5'd0, 32'h200, 32'h0, 32'hC, 1, 0, 0, 1);
    push("lu_store_stall", 1, 1, 32'h100, 32'h8, 32'h0, OP_ADD, 5'd4, 1, 1, 0, 1, 1, 16'd1);
    cyc();
    push("store_bubble", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'd2);
    cyc(); set_fwd(0, 0, 0, 1, 5'd4, 32'h77);
    push("sw_fwd", 1, 1, 32'h200, 32'hC, 32'h77, OP_ADD, 5'd0, 0, 0, 1, 0, 1, 16'd2);
    id_lw();

    cyc(); set_fwd(0, 0, 0, 0, 0, 0);
    id_add_dep(); bus.flush_87 = 1; bus.hold_87 = 1;
    push("flush_hold_nostall", 1, 1, 32'h100, 32'h8, 32'h0, OP_ADD, 5'd4, 1, 1, 0, 0, 1, 16'd2);
    cyc(); bus.flush_87 = 0; bus.hold_87 = 0; clr_id();
    push("flush_hold_bubble", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // saturation: 0xFFFF+2 flushed valid instructions
    id_add_dep(); bus.flush_87 = 1;
    repeat (32'h10001) cyc();
    bus.flush_87 = 0; clr_id();
    push("sat", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'hFFFF);
    id_add_dep(); bus.flush_87 = 1;
    cyc(); bus.flush_87 = 0; clr_id();
    push("sat_nowrap", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'hFFFF);

    // reset during a load-use stall
    id_lw();
    cyc(); id_add_dep();
    push("rst_pre_stall", 1, 1, 32'h100, 32'h8, 32'h0, OP_ADD, 5'd4, 1, 1, 0, 1, 1, 16'hFFFF);
    @(negedge clk); #1; rst = 1;
    cyc();
    push("rst_mid_stall", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(); rst = 0; clr_id();
    repeat (3) cyc();

    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
